tc_acq_arbiter: RTL and testbench

- Shares the single TileLink acquire/grant port of TagCacheTop among NREQ independent requesters (trace replayers, tag-walkers, perf probes).
- Arbitrates acquires round-robin and holds the grant for multi-beat puts.
- Tags each outgoing client_xact_id with the requester index and routes grants back by that index.
- Enforces a per-requester outstanding-transaction limit.

---
 rtl/tc_arb_pkg.sv | 24 ++
 rtl/tc_rr_picker.sv | 31 +++
 rtl/tc_acq_arbiter.sv | 169 ++++++++++++++++
 tb/tb_tc_acq_arbiter.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tc_arb_pkg.sv
// Shared types and helpers for the TagCacheTop acquire arbiter.
// Holds the built-in acquire/grant type encodings and the final-beat rule.
package tc_arb_pkg;

    typedef enum logic [2:0] {
        GetType   = 3'd0,
        GetBlock  = 3'd1,
        PutType   = 3'd2,
        PutBlock  = 3'd3,
        PutAtomic = 3'd4
    } a_type_e;

    typedef enum logic [3:0] {
        GetDataBlock = 4'd4
    } g_type_e;

    localparam logic [2:0] LAST_BEAT = 3'd7;

    // Only PutBlock spans several beats; every other acquire is done in one.
    function automatic logic is_final_acq(input logic [2:0] a_type, input logic [2:0] beat);
        return (a_type != PutBlock) || (beat == LAST_BEAT);
    endfunction

endpackage

// File: rtl/tc_rr_picker.sv
// Combinational round-robin selector: first set request at or after ptr.
// Returns the winner both one-hot and as a binary index.
module tc_rr_picker #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          any
);

    always_comb begin
        int j;
        // NOTE: every output gets a default before the loop, so no path leaves one unassigned and no latch is inferred.
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        j     = 0;
        for (int k = 0; k < N; k++) begin
            j = (int'(ptr) + k) % N;
            if (!any && req[j]) begin
                any      = 1'b1;
                grant[j] = 1'b1;
                idx      = IW'(j);
            end
        end
    end

endmodule

// File: rtl/tc_acq_arbiter.sv
// Shares one TileLink acquire/grant port among NREQ requesters: round-robin
// acquire arbitration with PutBlock locking, id tagging, and grant routing.
module tc_acq_arbiter
    import tc_arb_pkg::*;
#(
    parameter int NREQ   = 4,
    parameter int IDW    = 2,
    parameter int TLCIS  = 7,
    parameter int BLKW   = 26,
    parameter int TLDW   = 64,
    parameter int TLTW   = 4,
    parameter int MAXOUT = 8
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic [NREQ-1:0]               req_acq_valid,
    output logic [NREQ-1:0]               req_acq_ready,
    input  logic [NREQ*BLKW-1:0]          req_acq_addr_block,
    input  logic [NREQ*(TLCIS-IDW)-1:0]   req_acq_xact_id,
    input  logic [NREQ*3-1:0]             req_acq_beat,
    input  logic [NREQ*3-1:0]             req_acq_type,
    input  logic [NREQ*13-1:0]            req_acq_union,
    input  logic [NREQ*TLDW-1:0]          req_acq_data,
    input  logic [NREQ*TLTW-1:0]          req_acq_tag,
    output logic                          out_acq_valid,
    input  logic                          out_acq_ready,
    output logic [BLKW-1:0]               out_acq_addr_block,
    output logic [TLCIS-1:0]              out_acq_xact_id,
    output logic [2:0]                    out_acq_beat,
    output logic [2:0]                    out_acq_type,
    output logic [12:0]                   out_acq_union,
    output logic [TLDW-1:0]               out_acq_data,
    output logic [TLTW-1:0]               out_acq_tag,
    input  logic                          out_gnt_valid,
    output logic                          out_gnt_ready,
    input  logic [TLCIS-1:0]              out_gnt_xact_id,
    input  logic [2:0]                    out_gnt_beat,
    input  logic [3:0]                    out_gnt_type,
    output logic [NREQ-1:0]               req_gnt_valid,
    input  logic [NREQ-1:0]               req_gnt_ready,
    output logic [TLCIS-IDW-1:0]          req_gnt_xact_id,
    output logic                          err_unexp
);

    localparam int LIDW = TLCIS - IDW;
    localparam int CW   = $clog2(MAXOUT + 1);

    logic            lock;
    logic [IDW-1:0]  lock_idx;
    logic            hold;
    logic [IDW-1:0]  hold_idx;
    logic [IDW-1:0]  rr_ptr;
    logic [CW-1:0]   cnt [NREQ];

    logic [NREQ-1:0] eligible;
    logic [NREQ-1:0] pick_req;
    logic [NREQ-1:0] win_oh;
    logic [IDW-1:0]  win_idx;
    logic            win_any;
    logic            acq_fire;
    logic            acq_final;
    logic            acq_lock;
    logic [IDW-1:0]  gnt_idx;
    logic            gnt_final;
    logic [NREQ-1:0] cnt_inc;
    logic [NREQ-1:0] cnt_dec;

    always_comb begin
        for (int i = 0; i < NREQ; i++)
            eligible[i] = req_acq_valid[i] && (cnt[i] < CW'(MAXOUT));
    end

    // A locked burst owner bypasses its limit; a stalled winner keeps the port.
    always_comb begin
        pick_req = '0;
        if (lock)
            pick_req[lock_idx] = req_acq_valid[lock_idx];
        else if (hold && eligible[hold_idx])
            pick_req[hold_idx] = 1'b1;
        else
            pick_req = eligible;
    end

    tc_rr_picker #(
        .N  (NREQ),
        .IW (IDW)
    ) u_picker (
        .req   (pick_req),
        .ptr   (rr_ptr),
        .grant (win_oh),
        .idx   (win_idx),
        .any   (win_any)
    );

    assign out_acq_addr_block = req_acq_addr_block[int'(win_idx)*BLKW +: BLKW];
    assign out_acq_xact_id    = {win_idx, req_acq_xact_id[int'(win_idx)*LIDW +: LIDW]};
    assign out_acq_beat       = req_acq_beat[int'(win_idx)*3 +: 3];
    assign out_acq_type       = req_acq_type[int'(win_idx)*3 +: 3];
    assign out_acq_union      = req_acq_union[int'(win_idx)*13 +: 13];
    assign out_acq_data       = req_acq_data[int'(win_idx)*TLDW +: TLDW];
    assign out_acq_tag        = req_acq_tag[int'(win_idx)*TLTW +: TLTW];

    assign out_acq_valid = rstn && win_any;
    assign req_acq_ready = (rstn && out_acq_ready) ? win_oh : '0;
    assign acq_fire      = out_acq_valid && out_acq_ready;
    assign acq_final     = acq_fire && is_final_acq(out_acq_type, out_acq_beat);
    assign acq_lock      = acq_fire && (out_acq_type == PutBlock) && (out_acq_beat == 3'd0);

    assign gnt_idx         = out_gnt_xact_id[TLCIS-1 -: IDW];
    assign req_gnt_xact_id = out_gnt_xact_id[LIDW-1:0];
    assign out_gnt_ready   = rstn && req_gnt_ready[gnt_idx];
    assign gnt_final       = out_gnt_valid && out_gnt_ready &&
                             ((out_gnt_type != GetDataBlock) || (out_gnt_beat == LAST_BEAT));

    always_comb begin
        req_gnt_valid = '0;
        if (rstn)
            req_gnt_valid[gnt_idx] = out_gnt_valid;
    end

    // A grant against an empty counter is flagged but never decrements it.
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            cnt_inc[i] = acq_final && (win_idx == IDW'(i));
            cnt_dec[i] = gnt_final && (gnt_idx == IDW'(i)) && (cnt[i] != '0);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            lock      <= 1'b0;
            lock_idx  <= '0;
            hold      <= 1'b0;
            hold_idx  <= '0;
            rr_ptr    <= '0;
            err_unexp <= 1'b0;
            // NOTE: the counter array is control state, so every entry is reset, unlike a data memory.
            for (int i = 0; i < NREQ; i++)
                cnt[i] <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every flop reading pre-edge values.
            if (acq_fire) begin
                hold <= 1'b0;
                if (acq_final) begin
                    rr_ptr <= win_idx + 1'b1;
                    lock   <= 1'b0;
                end else if (acq_lock) begin
                    lock     <= 1'b1;
                    lock_idx <= win_idx;
                end
            end else begin
                hold     <= out_acq_valid;
                hold_idx <= win_idx;
            end

            if (gnt_final && (cnt[gnt_idx] == '0))
                err_unexp <= 1'b1;

            for (int i = 0; i < NREQ; i++) begin
                case ({cnt_inc[i], cnt_dec[i]})
                    2'b10:   cnt[i] <= cnt[i] + 1'b1;
                    2'b01:   cnt[i] <= cnt[i] - 1'b1;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tc_acq_arbiter.sv
// Directed bench for tc_acq_arbiter: arbitration, burst lock, limits,
// grant routing, unexpected grants and asynchronous reset.
module tb_tc_acq_arbiter;

    localparam int NREQ   = 4;
    localparam int IDW    = 2;
    localparam int TLCIS  = 7;
    localparam int BLKW   = 26;
    localparam int TLDW   = 64;
    localparam int TLTW   = 4;
    localparam int MAXOUT = 8;
    localparam int LIDW   = TLCIS - IDW;

    localparam logic [2:0] A_GET_TYPE  = 3'd0;
    localparam logic [2:0] A_GET_BLOCK = 3'd1;
    localparam logic [2:0] A_PUT_BLOCK = 3'd3;
    localparam logic [3:0] G_PUT_ACK   = 4'd2;
    localparam logic [3:0] G_GET_DBLK  = 4'd4;

    logic                        clk;
    logic                        rstn;
    logic [NREQ-1:0]             req_acq_valid;
    logic [NREQ-1:0]             req_acq_ready;
    logic [NREQ*BLKW-1:0]        req_acq_addr_block;
    logic [NREQ*LIDW-1:0]        req_acq_xact_id;
    logic [NREQ*3-1:0]           req_acq_beat;
    logic [NREQ*3-1:0]           req_acq_type;
    logic [NREQ*13-1:0]          req_acq_union;
    logic [NREQ*TLDW-1:0]        req_acq_data;
    logic [NREQ*TLTW-1:0]        req_acq_tag;
    logic                        out_acq_valid;
    logic                        out_acq_ready;
    logic [BLKW-1:0]             out_acq_addr_block;
    logic [TLCIS-1:0]            out_acq_xact_id;
    logic [2:0]                  out_acq_beat;
    logic [2:0]                  out_acq_type;
    logic [12:0]                 out_acq_union;
    logic [TLDW-1:0]             out_acq_data;
    logic [TLTW-1:0]             out_acq_tag;
    logic                        out_gnt_valid;
    logic                        out_gnt_ready;
    logic [TLCIS-1:0]            out_gnt_xact_id;
    logic [2:0]                  out_gnt_beat;
    logic [3:0]                  out_gnt_type;
    logic [NREQ-1:0]             req_gnt_valid;
    logic [NREQ-1:0]             req_gnt_ready;
    logic [LIDW-1:0]             req_gnt_xact_id;
    logic                        err_unexp;

    int passed = 0;
    int total  = 0;

    tc_acq_arbiter #(
        .NREQ(NREQ), .IDW(IDW), .TLCIS(TLCIS), .BLKW(BLKW),
        .TLDW(TLDW), .TLTW(TLTW), .MAXOUT(MAXOUT)
    ) dut (
        .clk                (clk),
        .rstn               (rstn),
        .req_acq_valid      (req_acq_valid),
        .req_acq_ready      (req_acq_ready),
        .req_acq_addr_block (req_acq_addr_block),
        .req_acq_xact_id    (req_acq_xact_id),
        .req_acq_beat       (req_acq_beat),
        .req_acq_type       (req_acq_type),
        .req_acq_union      (req_acq_union),
        .req_acq_data       (req_acq_data),
        .req_acq_tag        (req_acq_tag),
        .out_acq_valid      (out_acq_valid),
        .out_acq_ready      (out_acq_ready),
        .out_acq_addr_block (out_acq_addr_block),
        .out_acq_xact_id    (out_acq_xact_id),
        .out_acq_beat       (out_acq_beat),
        .out_acq_type       (out_acq_type),
        .out_acq_union      (out_acq_union),
        .out_acq_data       (out_acq_data),
        .out_acq_tag        (out_acq_tag),
        .out_gnt_valid      (out_gnt_valid),
        .out_gnt_ready      (out_gnt_ready),
        .out_gnt_xact_id    (out_gnt_xact_id),
        .out_gnt_beat       (out_gnt_beat),
        .out_gnt_type       (out_gnt_type),
        .req_gnt_valid      (req_gnt_valid),
        .req_gnt_ready      (req_gnt_ready),
        .req_gnt_xact_id    (req_gnt_xact_id),
        .err_unexp          (err_unexp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [TLDW-1:0] beat_data(input int i, input logic [2:0] b);
        return 64'hA5A5_0000_0000_0000 | (64'(i) << 8) | 64'(b);
    endfunction

    function automatic logic [BLKW-1:0] blk_addr(input int i);
        return BLKW'(32'h0012_3400 + i);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic [2:0] typ,
                           input logic [2:0] beat, input logic [LIDW-1:0] id);
        req_acq_valid[i]                  = v;
        req_acq_type[i*3 +: 3]            = typ;
        req_acq_beat[i*3 +: 3]            = beat;
        req_acq_xact_id[i*LIDW +: LIDW]   = id;
        req_acq_addr_block[i*BLKW +: BLKW] = blk_addr(i);
        req_acq_union[i*13 +: 13]         = 13'(i);
        req_acq_data[i*TLDW +: TLDW]      = beat_data(i, beat);
        req_acq_tag[i*TLTW +: TLTW]       = TLTW'(i + int'(beat));
    endtask

    task automatic set_gnt(input logic v, input logic [IDW-1:0] idx, input logic [LIDW-1:0] id,
                           input logic [3:0] typ, input logic [2:0] beat);
        out_gnt_valid   = v;
        out_gnt_xact_id = {idx, id};
        out_gnt_type    = typ;
        out_gnt_beat    = beat;
    endtask

    task automatic clear_inputs();
        req_acq_valid      = '0;
        req_acq_addr_block = '0;
        req_acq_xact_id    = '0;
        req_acq_beat       = '0;
        req_acq_type       = '0;
        req_acq_union      = '0;
        req_acq_data       = '0;
        req_acq_tag        = '0;
        out_acq_ready      = 1'b1;
        out_gnt_valid      = 1'b0;
        out_gnt_xact_id    = '0;
        out_gnt_beat       = '0;
        out_gnt_type       = '0;
        req_gnt_ready      = '0;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        clear_inputs();
        tick();
        tick();
        rstn = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        clear_inputs();
        req_acq_valid = '1;
        out_gnt_valid = 1'b1;
        req_gnt_ready = '1;
        #1;
        total++; if (out_acq_valid !== 1'b0) $display("FAIL reset_acq_valid: got %b want 0", out_acq_valid); else passed++;
        total++; if (req_acq_ready !== 4'b0000) $display("FAIL reset_acq_ready: got %b want 0000", req_acq_ready); else passed++;
        total++; if (req_gnt_valid !== 4'b0000) $display("FAIL reset_gnt_valid: got %b want 0000", req_gnt_valid); else passed++;
        total++; if (out_gnt_ready !== 1'b0) $display("FAIL reset_gnt_ready: got %b want 0", out_gnt_ready); else passed++;
        total++; if (err_unexp !== 1'b0) $display("FAIL reset_err: got %b want 0", err_unexp); else passed++;
        do_reset();
    endtask

    task automatic test_round_robin();
        do_reset();
        set_req(0, 1'b1, A_GET_BLOCK, 3'd0, 5'h0A);
        set_req(2, 1'b1, A_GET_BLOCK, 3'd0, 5'h13);
        #1;
        total++; if (req_acq_ready !== 4'b0001) $display("FAIL rr_first_ready: got %b want 0001", req_acq_ready); else passed++;
        total++; if (out_acq_xact_id !== 7'h0A) $display("FAIL rr_first_id: got %h want 0a", out_acq_xact_id); else passed++;
        total++; if (out_acq_addr_block !== blk_addr(0)) $display("FAIL rr_first_addr: got %h want %h", out_acq_addr_block, blk_addr(0)); else passed++;
        tick();
        req_acq_valid[0] = 1'b0;
        #1;
        total++; if (req_acq_ready !== 4'b0100) $display("FAIL rr_second_ready: got %b want 0100", req_acq_ready); else passed++;
        total++; if (out_acq_xact_id !== 7'h53) $display("FAIL rr_second_id: got %h want 53", out_acq_xact_id); else passed++;
        tick();
        req_acq_valid[2] = 1'b0;
        out_acq_ready    = 1'b0;
        set_req(1, 1'b1, A_GET_TYPE, 3'd0, 5'h01);
        set_req(3, 1'b1, A_GET_TYPE, 3'd0, 5'h03);
        req_acq_valid = 4'b1111;
        #1;
        total++; if (out_acq_xact_id[6:5] !== 2'd3) $display("FAIL rr_ptr_after: got idx %0d want 3", out_acq_xact_id[6:5]); else passed++;
        total++; if (req_acq_ready !== 4'b0000) $display("FAIL rr_stall_ready: got %b want 0000", req_acq_ready); else passed++;
    endtask

    task automatic test_putblock_lock();
        do_reset();
        set_req(3, 1'b1, A_GET_TYPE, 3'd0, 5'h07);
        for (int b = 0; b < 8; b++) begin
            set_req(1, 1'b1, A_PUT_BLOCK, 3'(b), 5'h11);
            if (b == 3) set_req(0, 1'b1, A_GET_TYPE, 3'd0, 5'h02);
            if (b == 4) begin
                out_acq_ready = 1'b0;
                #1;
                total++; if (req_acq_ready !== 4'b0000) $display("FAIL lock_stall_ready: got %b want 0000", req_acq_ready); else passed++;
                total++; if (out_acq_xact_id[6:5] !== 2'd1) $display("FAIL lock_stall_idx: got %0d want 1", out_acq_xact_id[6:5]); else passed++;
                tick();
                out_acq_ready = 1'b1;
            end
            if (b == 5) begin
                req_acq_valid[1] = 1'b0;
                #1;
                total++; if (out_acq_valid !== 1'b0) $display("FAIL lock_bubble_valid: got %b want 0", out_acq_valid); else passed++;
                tick();
                req_acq_valid[1] = 1'b1;
            end
            #1;
            total++; if (req_acq_ready !== 4'b0010) $display("FAIL lock_beat%0d_ready: got %b want 0010", b, req_acq_ready); else passed++;
            total++; if (out_acq_data !== beat_data(1, 3'(b))) $display("FAIL lock_beat%0d_data: got %h want %h", b, out_acq_data, beat_data(1, 3'(b))); else passed++;
            tick();
        end
        req_acq_valid[1] = 1'b0;
        #1;
        total++; if (req_acq_ready !== 4'b1000) $display("FAIL lock_release_ready: got %b want 1000", req_acq_ready); else passed++;
        tick();
        req_acq_valid[3] = 1'b0;
        #1;
        total++; if (req_acq_ready !== 4'b0001) $display("FAIL lock_then_req0: got %b want 0001", req_acq_ready); else passed++;
        tick();
        req_acq_valid[0] = 1'b0;
    endtask

    task automatic test_outstanding_limit();
        do_reset();
        set_req(0, 1'b1, A_GET_TYPE, 3'd0, 5'h01);
        for (int n = 0; n < MAXOUT; n++) begin
            #1;
            total++; if (req_acq_ready !== 4'b0001) $display("FAIL limit_acq%0d: got %b want 0001", n, req_acq_ready); else passed++;
            tick();
        end
        #1;
        total++; if (req_acq_ready !== 4'b0000) $display("FAIL limit_stall_ready: got %b want 0000", req_acq_ready); else passed++;
        total++; if (out_acq_valid !== 1'b0) $display("FAIL limit_stall_valid: got %b want 0", out_acq_valid); else passed++;
        set_req(1, 1'b1, A_GET_TYPE, 3'd0, 5'h04);
        #1;
        total++; if (req_acq_ready !== 4'b0010) $display("FAIL limit_req1_served: got %b want 0010", req_acq_ready); else passed++;
        tick();
        req_acq_valid[1] = 1'b0;
        req_gnt_ready    = 4'b0001;
        set_gnt(1'b1, 2'd0, 5'h01, G_PUT_ACK, 3'd0);
        #1;
        total++; if (req_acq_ready !== 4'b0000) $display("FAIL limit_still_stalled: got %b want 0000", req_acq_ready); else passed++;
        total++; if (req_gnt_valid !== 4'b0001) $display("FAIL limit_gnt_route: got %b want 0001", req_gnt_valid); else passed++;
        total++; if (out_gnt_ready !== 1'b1) $display("FAIL limit_gnt_ready: got %b want 1", out_gnt_ready); else passed++;
        total++; if (req_gnt_xact_id !== 5'h01) $display("FAIL limit_gnt_id: got %h want 01", req_gnt_xact_id); else passed++;
        tick();
        out_gnt_valid = 1'b0;
        #1;
        total++; if (req_acq_ready !== 4'b0001) $display("FAIL limit_unblocked: got %b want 0001", req_acq_ready); else passed++;
        tick();
        req_acq_valid[0] = 1'b0;
    endtask

    task automatic test_grant_multibeat();
        do_reset();
        set_req(2, 1'b1, A_GET_BLOCK, 3'd0, 5'h07);
        repeat (MAXOUT) tick();
        #1;
        total++; if (req_acq_ready !== 4'b0000) $display("FAIL gdb_req2_full: got %b want 0000", req_acq_ready); else passed++;
        for (int b = 0; b < 8; b++) begin
            set_gnt(1'b1, 2'd2, 5'h07, G_GET_DBLK, 3'(b));
            req_gnt_ready = 4'b1011;
            #1;
            total++; if (req_gnt_valid !== 4'b0100) $display("FAIL gdb_beat%0d_route: got %b want 0100", b, req_gnt_valid); else passed++;
            total++; if (out_gnt_ready !== 1'b0) $display("FAIL gdb_beat%0d_noready: got %b want 0", b, out_gnt_ready); else passed++;
            tick();
            req_gnt_ready = 4'b0100;
            #1;
            total++; if (out_gnt_ready !== 1'b1) $display("FAIL gdb_beat%0d_ready: got %b want 1", b, out_gnt_ready); else passed++;
            total++; if (req_acq_ready !== 4'b0000) $display("FAIL gdb_beat%0d_early_dec: got %b want 0000", b, req_acq_ready); else passed++;
            tick();
        end
        out_gnt_valid = 1'b0;
        #1;
        total++; if (req_acq_ready !== 4'b0100) $display("FAIL gdb_final_dec: got %b want 0100", req_acq_ready); else passed++;
        total++; if (err_unexp !== 1'b0) $display("FAIL gdb_no_err: got %b want 0", err_unexp); else passed++;
        tick();
        req_acq_valid[2] = 1'b0;
    endtask

    task automatic test_unexpected_grant();
        do_reset();
        req_gnt_ready = 4'b1000;
        set_gnt(1'b1, 2'd3, 5'h00, G_PUT_ACK, 3'd0);
        #1;
        total++; if (req_gnt_valid !== 4'b1000) $display("FAIL unexp_delivered: got %b want 1000", req_gnt_valid); else passed++;
        tick();
        out_gnt_valid = 1'b0;
        #1;
        total++; if (err_unexp !== 1'b1) $display("FAIL unexp_set: got %b want 1", err_unexp); else passed++;
        repeat (3) tick();
        total++; if (err_unexp !== 1'b1) $display("FAIL unexp_sticky: got %b want 1", err_unexp); else passed++;
        set_req(3, 1'b1, A_GET_TYPE, 3'd0, 5'h09);
        for (int n = 0; n < MAXOUT; n++) begin
            #1;
            total++; if (req_acq_ready !== 4'b1000) $display("FAIL unexp_cnt_acq%0d: got %b want 1000", n, req_acq_ready); else passed++;
            tick();
        end
        #1;
        total++; if (req_acq_ready !== 4'b0000) $display("FAIL unexp_cnt_nowrap: got %b want 0000", req_acq_ready); else passed++;
        req_acq_valid[3] = 1'b0;
        rstn = 1'b0;
        #1;
        total++; if (err_unexp !== 1'b0) $display("FAIL unexp_async_clear: got %b want 0", err_unexp); else passed++;
        tick();
        rstn = 1'b1;
        tick();
    endtask

    task automatic test_reset_midburst();
        do_reset();
        set_req(2, 1'b1, A_GET_TYPE, 3'd0, 5'h05);
        tick();
        req_acq_valid[2] = 1'b0;
        req_gnt_ready = 4'b0001;
        set_gnt(1'b1, 2'd0, 5'h00, G_PUT_ACK, 3'd0);
        tick();
        out_gnt_valid = 1'b0;
        #1;
        total++; if (err_unexp !== 1'b1) $display("FAIL mid_err_pre: got %b want 1", err_unexp); else passed++;
        for (int b = 0; b < 4; b++) begin
            set_req(1, 1'b1, A_PUT_BLOCK, 3'(b), 5'h0C);
            tick();
        end
        set_req(1, 1'b1, A_PUT_BLOCK, 3'd4, 5'h0C);
        set_req(3, 1'b1, A_GET_TYPE, 3'd0, 5'h0E);
        #1;
        total++; if (req_acq_ready !== 4'b0010) $display("FAIL mid_locked_beat4: got %b want 0010", req_acq_ready); else passed++;
        rstn = 1'b0;
        #1;
        total++; if (out_acq_valid !== 1'b0) $display("FAIL mid_reset_valid: got %b want 0", out_acq_valid); else passed++;
        total++; if (err_unexp !== 1'b0) $display("FAIL mid_reset_err: got %b want 0", err_unexp); else passed++;
        tick();
        rstn = 1'b1;
        req_acq_valid[1] = 1'b0;
        set_req(2, 1'b1, A_GET_TYPE, 3'd0, 5'h06);
        #1;
        total++; if (req_acq_ready !== 4'b0100) $display("FAIL mid_after_reset_winner: got %b want 0100", req_acq_ready); else passed++;
        total++; if (out_acq_xact_id !== 7'h46) $display("FAIL mid_after_reset_id: got %h want 46", out_acq_xact_id); else passed++;
        tick();
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_putblock_lock();
        test_outstanding_limit();
        test_grant_multibeat();
        test_unexpected_grant();
        test_reset_midburst();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
